// File: rtl/vec_cache_rd_req_master_arbiter_pkg.sv
// rtl/vec_cache_rd_req_master_arbiter_pkg.sv - request payload types and default sizes
// Purpose: shared typedefs for the read-request master arbiter.
// Contents: default N/M, field widths, us_req_pld_t and a master_id stamping helper.
package vec_cache_rd_req_master_arbiter_pkg;

  localparam int DEF_N  = 16;
  localparam int DEF_M  = 8;
  localparam int MID_W  = $clog2(DEF_N);
  localparam int DEST_W = $clog2(DEF_M);
  localparam int SEQ_W  = 8;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;

  typedef struct packed {
    logic [MID_W-1:0] master_id;
    logic [SEQ_W-1:0] seq;
  } txn_id_t;

  typedef struct packed {
    txn_id_t           txn_id;
    logic [DEST_W-1:0] dest_id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
  } us_req_pld_t;

  // Replace only txn_id.master_id; the return path routes data on this field.
  function automatic us_req_pld_t stamp_master(us_req_pld_t p, logic [MID_W-1:0] id);
    us_req_pld_t r;
    r = p;
    r.txn_id.master_id = id;
    return r;
  endfunction

endpackage

// File: rtl/vec_cache_rd_req_master_arbiter_if.sv
// rtl/vec_cache_rd_req_master_arbiter_if.sv - upstream/downstream request bus bundle
// Purpose: groups per-master request handshake and per-channel output handshake.
// Signals: in_vld/in_pld/in_rdy (N masters), out_vld/out_pld/out_rdy (M channels).
// Modports: slave = arbiter side, master = request sources plus downstream sink.
interface vec_cache_rd_req_master_arbiter_if
  import vec_cache_rd_req_master_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) ();

  logic [N-1:0] in_vld;
  us_req_pld_t  in_pld  [N-1:0];
  logic [N-1:0] in_rdy;
  logic [M-1:0] out_vld;
  us_req_pld_t  out_pld [M-1:0];
  logic [M-1:0] out_rdy;

  modport slave (
    input  in_vld, in_pld, out_rdy,
    output in_rdy, out_vld, out_pld
  );

  modport master (
    output in_vld, in_pld, out_rdy,
    input  in_rdy, out_vld, out_pld
  );

endinterface

// File: rtl/vec_cache_rd_req_master_arbiter_rr_arb.sv
// rtl/vec_cache_rd_req_master_arbiter_rr_arb.sv - N-way round-robin arbiter
// Purpose: picks the first requester at or after the registered pointer, wrapping.
// Ports: clk, rst (sync, active-high), i_req[N], i_en, o_gnt_onehot[N], o_gnt_idx.
// The pointer moves to winner+1 only when a grant is issued.
module vec_cache_rr_arb #(
  parameter  int N     = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt_onehot,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  function automatic int wrap_idx(int base, int k);
    int s;
    s = base + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Walk from the pointer and stop at the first asserted request.
  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    w_found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_en && !w_found && i_req[IDX_W'(wrap_idx(int'(r_ptr), k))]) begin
        w_found                                         = 1'b1;
        o_gnt_idx                                       = IDX_W'(wrap_idx(int'(r_ptr), k));
        o_gnt_onehot[IDX_W'(wrap_idx(int'(r_ptr), k))] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vec_cache_rd_req_master_arbiter.sv
// rtl/vec_cache_rd_req_master_arbiter.sv - per-channel round-robin read-request collector
// Purpose: steers each master request to channel dest_id, arbitrates per channel,
//          stamps txn_id.master_id with the winner, registers the result.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//        in_vld/in_pld in, in_rdy out (combinational grant),
//        out_vld/out_pld out (registered), out_rdy in.
module vec_cache_rd_req_master_arbiter
  import vec_cache_rd_req_master_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input logic                                clk,
  input logic                                rst,
  vec_cache_rd_req_master_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(N);

  logic [M-1:0]     w_ld_en;
  logic [M-1:0]     w_gnt_vld;
  logic [N-1:0]     w_req        [M-1:0];
  logic [N-1:0]     w_gnt_onehot [M-1:0];
  logic [IDX_W-1:0] w_gnt_idx    [M-1:0];
  us_req_pld_t      w_ld_pld     [M-1:0];
  logic [N-1:0]     w_in_rdy;

  logic [M-1:0]     r_out_vld;
  us_req_pld_t      r_out_pld    [M-1:0];

  // A full slot that drains this cycle can take a new request in the same cycle.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      w_ld_en[j] = !r_out_vld[j] || bus.out_rdy[j];
      w_req[j]   = '0;
      for (int i = 0; i < N; i++) begin
        w_req[j][i] = bus.in_vld[i] && (bus.in_pld[i].dest_id == DEST_W'(j));
      end
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_chan
    vec_cache_rr_arb #(.N(N)) u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_req        (w_req[j]),
      .i_en         (w_ld_en[j]),
      .o_gnt_onehot (w_gnt_onehot[j]),
      .o_gnt_idx    (w_gnt_idx[j])
    );
  end

  // A master has one dest_id, so at most one channel's grant vector hits it.
  always_comb begin
    w_in_rdy = '0;
    for (int j = 0; j < M; j++) begin
      w_gnt_vld[j] = |w_gnt_onehot[j];
      w_ld_pld[j]  = stamp_master(bus.in_pld[w_gnt_idx[j]], MID_W'(w_gnt_idx[j]));
      w_in_rdy     = w_in_rdy | w_gnt_onehot[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= '0;
      for (int j = 0; j < M; j++) begin
        r_out_pld[j] <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        if (w_gnt_vld[j]) begin
          r_out_vld[j] <= 1'b1;
          r_out_pld[j] <= w_ld_pld[j];
        end else if (bus.out_rdy[j]) begin
          r_out_vld[j] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_rdy  = w_in_rdy;
  assign bus.out_vld = r_out_vld;
  assign bus.out_pld = r_out_pld;

endmodule
